// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-ported SRAM between fetch and data requesters.
// Data wins contention; a streak counter forces a fetch grant after DATA_STREAK_MAX data grants.
module sram_port_arbiter #(
    parameter int DATA_STREAK_MAX = 4,
    parameter int ADDR_W          = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_gnt,
    output logic              inst_rvalid,
    output logic [63:0]       inst_rdata,
    input  logic              data_req,
    input  logic [7:0]        data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [63:0]       data_wdata,
    output logic              data_gnt,
    output logic              data_rvalid,
    output logic [63:0]       data_rdata,
    output logic              mem_en,
    output logic [7:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       mem_rdata,
    output logic              stallreq
);
    typedef enum logic [1:0] {OWN_NONE, OWN_INST, OWN_DATA} owner_t;

    logic [3:0] streak_q, streak_d;
    owner_t     owner_q, owner_d;
    logic       store_q, store_d;
    logic       force_inst;

    always_comb begin
        force_inst  = inst_req && data_req && (streak_q == 4'(DATA_STREAK_MAX));
        // Grants are gated by rst_n so nothing reaches the SRAM while in reset.
        inst_gnt    = rst_n && inst_req && (!data_req || force_inst);
        data_gnt    = rst_n && data_req && !force_inst;
        mem_en      = inst_gnt || data_gnt;
        mem_we      = data_gnt ? data_we : 8'h00;
        mem_addr    = data_gnt ? data_addr : inst_addr;
        mem_wdata   = data_gnt ? data_wdata : 64'h0;
        stallreq    = rst_n && ((inst_req && !inst_gnt) || (data_req && !data_gnt));
        streak_d    = (inst_gnt || !inst_req) ? 4'd0 :
                      (data_gnt && streak_q < 4'(DATA_STREAK_MAX)) ? streak_q + 4'd1 : streak_q;
        owner_d     = inst_gnt ? OWN_INST : data_gnt ? OWN_DATA : OWN_NONE;
        store_d     = data_gnt && (data_we != 8'h00);
        inst_rvalid = owner_q == OWN_INST;
        data_rvalid = owner_q == OWN_DATA;
        inst_rdata  = inst_rvalid ? mem_rdata : 64'h0;
        data_rdata  = (data_rvalid && !store_q) ? mem_rdata : 64'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q <= 4'd0;
            owner_q  <= OWN_NONE;
            store_q  <= 1'b0;
        end else begin
            streak_q <= streak_d;
            owner_q  <= owner_d;
            store_q  <= store_d;
        end
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: per-cycle directed vectors with hand-computed expectations.
module tb_sram_port_arbiter;
    localparam logic [63:0] IADDR = 64'h8000_0000;

    logic        clk = 0, rst_n = 0;
    logic        inst_req = 0, inst_gnt, inst_rvalid;
    logic [63:0] inst_addr = IADDR, inst_rdata;
    logic        data_req = 0, data_gnt, data_rvalid;
    logic [7:0]  data_we = 0, mem_we;
    logic [63:0] data_addr = 0, data_wdata = 0, data_rdata;
    logic        mem_en, stallreq;
    logic [63:0] mem_addr, mem_wdata, mem_rdata = 0;
    int          checks = 0, errors = 0, cyc = 0;

    sram_port_arbiter #(.DATA_STREAK_MAX(4), .ADDR_W(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
        .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
        .data_rdata(data_rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stallreq(stallreq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r, ir, dr;
        logic [7:0]  we;
        logic [63:0] da, wd, rd;
        logic        ig, dg, iv, dv, st;
        logic [63:0] ird, drd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, ir, dr, input logic [7:0] we,
                                input logic [63:0] da, wd, rd,
                                input logic ig, dg, iv, dv, st,
                                input logic [63:0] ird, drd);
        vec_t v;
        v.r = r; v.ir = ir; v.dr = dr; v.we = we; v.da = da; v.wd = wd; v.rd = rd;
        v.ig = ig; v.dg = dg; v.iv = iv; v.dv = dv; v.st = st; v.ird = ird; v.drd = drd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL cycle %0d %s got %h want %h", cyc, name, act, exp);
        end
    endtask

    // Drive one cycle's inputs at negedge, check outputs 1ns later.
    task automatic apply(input vec_t v);
        @(negedge clk);
        rst_n = v.r; inst_req = v.ir; data_req = v.dr; data_we = v.we;
        data_addr = v.da; data_wdata = v.wd; mem_rdata = v.rd;
        #1;
        chk("inst_gnt", 64'(inst_gnt), 64'(v.ig));
        chk("data_gnt", 64'(data_gnt), 64'(v.dg));
        chk("mem_en", 64'(mem_en), 64'(v.ig | v.dg));
        chk("mem_we", 64'(mem_we), v.dg ? 64'(v.we) : 64'h0);
        chk("stallreq", 64'(stallreq), 64'(v.st));
        chk("inst_rvalid", 64'(inst_rvalid), 64'(v.iv));
        chk("data_rvalid", 64'(data_rvalid), 64'(v.dv));
        chk("inst_rdata", inst_rdata, v.ird);
        chk("data_rdata", data_rdata, v.drd);
        if (v.ig | v.dg) begin
            chk("mem_addr", mem_addr, v.dg ? v.da : IADDR);
            chk("mem_wdata", mem_wdata, v.dg ? v.wd : 64'h0);
        end
        cyc++;
    endtask

    initial begin
        // reset with both requests high, then release: data first, inst stalled
        tbl.push_back(mk(0,1,1,8'h00,64'h200,0,0,             0,0,0,0,0, 0,0));
        tbl.push_back(mk(1,1,1,8'h00,64'h200,0,0,             0,1,0,0,1, 0,0));
        // solo fetch; data read response from previous cycle
        tbl.push_back(mk(1,1,0,8'h00,0,0,64'h1111,            1,0,0,1,0, 0,64'h1111));
        tbl.push_back(mk(1,0,0,8'h00,0,0,64'h0000_0013_0000_0093, 0,0,1,0,0, 64'h0000_0013_0000_0093,0));
        // store, then load from same address
        tbl.push_back(mk(1,0,1,8'hFF,64'h100,64'hDEADBEEF_CAFEF00D,64'h5555, 0,1,0,0,0, 0,0));
        tbl.push_back(mk(1,0,1,8'h00,64'h100,0,64'h5555,      0,1,0,1,0, 0,0));
        tbl.push_back(mk(1,0,0,8'h00,0,0,64'hDEADBEEF_CAFEF00D, 0,0,0,1,0, 0,64'hDEADBEEF_CAFEF00D));
        // continuous contention: D,D,D,D,I,D,D,D,D,I
        for (int k = 0; k < 10; k++) begin
            logic ig, pi, pd;
            logic [63:0] rd;
            ig = (k == 4) || (k == 9);
            pi = (k == 5);
            pd = (k != 0) && (k != 5);
            rd = 64'hC0DE_0000_0000_0000 + 64'(k);
            tbl.push_back(mk(1,1,1,8'h00,64'h300,0,rd, ig,!ig,pi,pd,1, pi ? rd : 64'h0, pd ? rd : 64'h0));
        end
        tbl.push_back(mk(1,0,0,8'h00,0,0,64'h77,              0,0,1,0,0, 64'h77,0));
        foreach (tbl[i]) apply(tbl[i]);

        // byte store while a fetch arrives: fetch granted next cycle
        apply(mk(1,1,1,8'h01,64'h108,64'hAB,64'h99,           0,1,0,0,1, 0,0));
        apply(mk(1,1,0,8'h00,0,0,64'h99,                      1,0,0,1,0, 0,0));
        apply(mk(1,0,0,8'h00,0,0,64'h42,                      0,0,1,0,0, 64'h42,0));

        // reset the cycle after a data read grant drops the response
        apply(mk(1,0,1,8'h00,64'h400,0,64'h0,                 0,1,0,0,0, 0,0));
        apply(mk(0,1,1,8'h00,64'h400,0,64'hFEED,              0,0,0,0,0, 0,0));
        apply(mk(1,0,0,8'h00,0,0,64'hFEED,                    0,0,0,0,0, 0,0));
        apply(mk(1,0,0,8'h00,0,0,64'hFEED,                    0,0,0,0,0, 0,0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-ported 64-bit synchronous SRAM between the pipeline's instruction-fetch requester and data (load/store) requester.
- Sits between the CPU core and a single `sram` instance, as a single-memory alternative to separate instruction and data SRAMs.
- Data requests normally win; a starvation counter forces periodic fetch grants.
- Routes the 1-cycle-latency read data back to the requester that was granted, and raises a stall request to the core whenever a requester is held off.

Parameters:
- DATA_STREAK_MAX, 4, max consecutive data grants while inst_req is pending before one inst grant is forced (1..15).
- ADDR_W, 64, address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- inst_req  in  1  fetch request (read only).
- inst_addr  in  ADDR_W  fetch address.
- inst_gnt  out  1  fetch request accepted this cycle.
- inst_rvalid  out  1  inst_rdata valid.
- inst_rdata  out  64  fetch read data.
- data_req  in  1  data request.
- data_we  in  8  byte write enables; 0 means read.
- data_addr  in  ADDR_W  data address.
- data_wdata  in  64  store data.
- data_gnt  out  1  data request accepted this cycle.
- data_rvalid  out  1  response strobe: load data valid, or store complete.
- data_rdata  out  64  load data.
- mem_en  out  1  SRAM enable.
- mem_we  out  8  SRAM byte write enables.
- mem_addr  out  ADDR_W  SRAM address.
- mem_wdata  out  64  SRAM write data.
- mem_rdata  in  64  SRAM read data, valid one cycle after mem_en with mem_we=0.
- stallreq  out  1  core must hold its pipeline this cycle.

Behaviour:
- Grant logic is combinational from inputs and state; at most one grant per cycle.
  - Grant decision: if both requests are pending, data wins unless streak_cnt == DATA_STREAK_MAX, in which case inst wins.
  - Single requester is granted immediately.
- Memory port, combinationally from the winner:
  - mem_en = inst_gnt | data_gnt.
  - mem_addr and mem_wdata are taken from the winner.
  - mem_we = data_we when data wins; 0 when inst wins or nothing is granted.
  - mem_wdata = 0 when inst wins.
- streak_cnt, 4-bit register:
  - Increments on a data grant while inst_req=1.
  - Clears on an inst grant, or on any cycle with inst_req=0.
  - Saturates at DATA_STREAK_MAX.
- Response tracking, registered:
  - resp_owner: 0=none, 1=inst, 2=data. It is set at the clock edge after a grant.
  - Cycle after an inst grant: inst_rvalid=1, inst_rdata=mem_rdata.
  - Cycle after a data grant: data_rvalid=1. For a read, data_rdata=mem_rdata; for a store, data_rdata=0 and the strobe is an ack only.
  - rvalid strobes are single-cycle. There is no response back-pressure; requesters must sample on rvalid.
  - rdata outputs are 0 whenever the matching rvalid=0.
- Requester rules:
  - A requester holds req, addr, wdata and we stable until gnt.
  - It may assert a new req in the same cycle it receives rvalid; back-to-back grants give one grant per cycle, with full throughput.
- stallreq = (inst_req & ~inst_gnt) | (data_req & ~data_gnt).
- Reset (rst_n=0, asynchronous):
  - streak_cnt=0, resp_owner=none.
  - All rvalid and rdata outputs = 0.
  - While in reset, grants, mem_en, mem_we and stallreq are forced 0.
  - Reset mid-transaction drops any pending response: no rvalid after release.
- Simultaneous data grant reaching the streak limit: the next contended cycle goes to inst regardless of data_req.
- No state machine beyond streak_cnt and resp_owner. Address is not decoded; no misalignment check.

Test Plan:
- Reset: hold rst_n=0 with both reqs high -> all grants, mem_en, mem_we, rvalid and stallreq = 0. Release -> first cycle data granted, inst stalled, stallreq=1.
- Solo fetch: inst_req with inst_addr=0x80000000, mem_rdata=0x0000_0013_0000_0093 the next cycle -> inst_gnt=1 at cycle 0; inst_rvalid=1 and inst_rdata=0x0000_0013_0000_0093 at cycle 1; stallreq=0.
- Store then load: data_we=0xFF, addr 0x100, wdata=0xDEADBEEF_CAFEF00D -> mem_we=0xFF, data_rvalid ack with data_rdata=0 next cycle. Then a load from 0x100 -> data_rdata=0xDEADBEEF_CAFEF00D.
- Contention, DATA_STREAK_MAX=4, both reqs held high continuously -> grant sequence D,D,D,D,I,D,D,D,D,I…; stallreq=1 every cycle; inst_rvalid one cycle after each I.
- Byte store: data_we=0x01 -> mem_we=0x01 and no inst grant that cycle. A fetch arriving the same cycle -> inst_gnt the following cycle.
- Reset asserted the cycle after a data read grant -> data_rvalid never asserts; after release, resp_owner=none.
